// File: rtl/alu_result_stage.sv
// alu_result_stage: captures ALU result into Z, maintains HI/LO, and serialises results as 1-2 bus beats.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter logic [4:0] MUL_OP = 5'b01110,
  parameter logic [4:0] DIV_OP = 5'b01111,
  parameter logic [4:0] MFHI_OP = 5'b10111,
  parameter logic [4:0] MFLO_OP = 5'b11000,
  parameter logic [4:0] NOP_OP = 5'b11001,
  parameter logic [4:0] HALT_OP = 5'b11010
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [2*DATA_W-1:0] c_in,
  input  logic [4:0]          opcode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_hi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   hi_q,
  output logic [DATA_W-1:0]   lo_q,
  output logic [2*DATA_W-1:0] z_q,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BEAT_LO = 2'd1;
  localparam logic [1:0] BEAT_HI = 2'd2;
  logic [1:0] state;
  logic wide;
  logic is_wide, is_nop, is_halt, last_beat, acc;
  logic [2*DATA_W-1:0] z_next;
  assign is_wide = opcode == MUL_OP || opcode == DIV_OP;
  assign is_nop = opcode == NOP_OP;
  assign is_halt = opcode == HALT_OP;
  assign out_valid = state != IDLE;
  assign out_hi = state == BEAT_HI;
  assign out_data = state == BEAT_LO ? z_q[DATA_W-1:0] : state == BEAT_HI ? z_q[2*DATA_W-1:DATA_W] : '0;
  assign last_beat = state == BEAT_HI || (state == BEAT_LO && !wide);
  assign in_ready = !clear && !halted && (state == IDLE || (out_valid && out_ready && last_beat));
  assign acc = in_valid && in_ready;
  // mfhi/mflo sample HI/LO as they stand before this edge
  assign z_next = is_wide ? c_in
                : opcode == MFHI_OP ? {{DATA_W{1'b0}}, hi_q}
                : opcode == MFLO_OP ? {{DATA_W{1'b0}}, lo_q}
                : {{DATA_W{1'b0}}, c_in[DATA_W-1:0]};
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      wide <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      z_q <= '0;
      halted <= 1'b0;
      retired <= '0;
    end else if (acc) begin
      if (is_halt || is_nop) begin
        state <= IDLE;
        halted <= halted | is_halt;
      end else begin
        state <= BEAT_LO;
        wide <= is_wide;
        z_q <= z_next;
        retired <= retired + CNT_W'(1);
        if (is_wide) begin
          hi_q <= c_in[2*DATA_W-1:DATA_W];
          lo_q <= c_in[DATA_W-1:0];
        end
      end
    end else if (out_valid && out_ready) begin
      state <= (state == BEAT_LO && wide) ? BEAT_HI : IDLE;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed checks of beat sequencing, HI/LO, backpressure, halt and counter wrap.
module tb_alu_result_stage;
  localparam logic [4:0] ADD = 5'b00001, MUL = 5'b01110, DIV = 5'b01111;
  localparam logic [4:0] MFHI = 5'b10111, MFLO = 5'b11000, NOP = 5'b11001, HALT = 5'b11010;
  logic clock = 1'b0, clear = 1'b1;
  logic [63:0] c_in = '0;
  logic [4:0] opcode = ADD;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_hi, out_valid, halted;
  logic [31:0] out_data, hi_q, lo_q;
  logic [63:0] z_q;
  logic [15:0] retired;
  int checks = 0, failures = 0;
  alu_result_stage dut (
    .clock(clock), .clear(clear), .c_in(c_in), .opcode(opcode), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_hi(out_hi), .out_valid(out_valid),
    .out_ready(out_ready), .hi_q(hi_q), .lo_q(lo_q), .z_q(z_q), .halted(halted), .retired(retired)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [4:0] op, input logic [63:0] c);
    opcode = op;
    c_in = c;
    in_valid = 1'b1;
  endtask
  initial begin
    #12 clear = 1'b0;
    #1;
    // reset mid BEAT_HI of a MUL
    issue(MUL, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    in_valid = 1'b0;
    step();
    check("pre_rst_hi", {63'd0, out_hi}, 64'd1);
    clear = 1'b1;
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_hi", {63'd0, out_hi}, 64'd0);
    check("rst_data", {32'd0, out_data}, 64'd0);
    check("rst_hiq", {32'd0, hi_q}, 64'd0);
    check("rst_z", z_q, 64'd0);
    check("rst_retired", {48'd0, retired}, 64'd0);
    check("rst_inready_clr", {63'd0, in_ready}, 64'd0);
    clear = 1'b0;
    #1;
    check("rst_inready", {63'd0, in_ready}, 64'd1);
    step();
    // ADD single beat
    issue(ADD, 64'h7);
    step();
    in_valid = 1'b0;
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_data", {32'd0, out_data}, 64'h7);
    check("add_hi", {63'd0, out_hi}, 64'd0);
    check("add_retired", {48'd0, retired}, 64'd1);
    step();
    check("add_done", {63'd0, out_valid}, 64'd0);
    check("idle_data", {32'd0, out_data}, 64'd0);
    // NOP: accepted, no beat, retired unchanged
    issue(NOP, 64'h55);
    step();
    in_valid = 1'b0;
    check("nop_valid", {63'd0, out_valid}, 64'd0);
    check("nop_retired", {48'd0, retired}, 64'd1);
    check("nop_z", z_q, 64'h7);
    // MUL two beats
    issue(MUL, 64'h1234_5678_9ABC_DEF0);
    step();
    in_valid = 1'b0;
    check("mul_b0", {32'd0, out_data}, 64'h9ABC_DEF0);
    check("mul_b0_hi", {63'd0, out_hi}, 64'd0);
    check("mul_b0_inready", {63'd0, in_ready}, 64'd0);
    check("mul_hiq", {32'd0, hi_q}, 64'h1234_5678);
    check("mul_loq", {32'd0, lo_q}, 64'h9ABC_DEF0);
    step();
    check("mul_b1", {32'd0, out_data}, 64'h1234_5678);
    check("mul_b1_hi", {63'd0, out_hi}, 64'd1);
    check("mul_b1_inready", {63'd0, in_ready}, 64'd1);
    step();
    check("mul_done", {63'd0, out_valid}, 64'd0);
    check("mul_retired", {48'd0, retired}, 64'd2);
    // DIV then MFHI/MFLO back-to-back
    issue(DIV, {32'd3, 32'd5});
    step();
    issue(MFHI, 64'hDEAD);
    check("div_b0", {32'd0, out_data}, 64'd5);
    check("div_b0_inready", {63'd0, in_ready}, 64'd0);
    step();
    check("div_b1", {32'd0, out_data}, 64'd3);
    check("div_b1_hi", {63'd0, out_hi}, 64'd1);
    step();
    opcode = MFLO;
    check("mfhi_data", {32'd0, out_data}, 64'd3);
    check("mfhi_hi", {63'd0, out_hi}, 64'd0);
    check("mfhi_z", z_q, 64'd3);
    step();
    in_valid = 1'b0;
    check("mflo_data", {32'd0, out_data}, 64'd5);
    check("mflo_z", z_q, 64'd5);
    check("div_hiq", {32'd0, hi_q}, 64'd3);
    check("div_loq", {32'd0, lo_q}, 64'd5);
    step();
    check("mf_done", {63'd0, out_valid}, 64'd0);
    check("mf_retired", {48'd0, retired}, 64'd5);
    // backpressure
    out_ready = 1'b0;
    issue(ADD, 64'hFFFF_FFFF_0000_00AB);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_data", {32'd0, out_data}, 64'hAB);
      check("bp_inready", {63'd0, in_ready}, 64'd0);
      step();
    end
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_z", z_q, 64'hAB);
    out_ready = 1'b1;
    step();
    check("bp_done", {63'd0, out_valid}, 64'd0);
    check("bp_retired", {48'd0, retired}, 64'd6);
    // drive retired to its maximum, then wrap
    issue(ADD, 64'h1);
    for (int i = 0; i < 65529; i++) step();
    in_valid = 1'b0;
    check("cnt_max", {48'd0, retired}, 64'hFFFF);
    step();
    issue(ADD, 64'h2);
    step();
    in_valid = 1'b0;
    check("cnt_wrap", {48'd0, retired}, 64'd0);
    step();
    // HALT
    issue(HALT, 64'h9);
    step();
    in_valid = 1'b0;
    check("halt_flag", {63'd0, halted}, 64'd1);
    check("halt_inready", {63'd0, in_ready}, 64'd0);
    check("halt_valid", {63'd0, out_valid}, 64'd0);
    issue(ADD, 64'h44);
    step();
    step();
    in_valid = 1'b0;
    check("halt_nobeat", {63'd0, out_valid}, 64'd0);
    check("halt_retired", {48'd0, retired}, 64'd0);
    check("halt_z", z_q, 64'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
